bus_cycle_control: RTL and testbench

//  T-state sequencer for one external bus cycle: opcode fetch (M1), memory read/write, IO read/write.

---
 rtl/bus_cycle_control.sv | 153 +++++++++++++++
 tb/tb_bus_cycle_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_control.sv
// bus_cycle_control: T-state sequencer for a single Z80-style external bus cycle.
//
// Cycle types: opcode fetch (M1), memory read/write, and IO read/write.
// The block drives the address/data pin-block enables and the control strobes.
// It also reports cycle completion back to the instruction sequencer.
//
// Optional feature: define BUS_CYCLE_WAIT_EN to honour nWAIT and allow TW states.
//   - Without it, nWAIT is ignored.
//   - Every cycle then has a fixed length: fetch 4, mem 3, IO 3+IO_WAITS clocks.
//
// state | meaning
// IDLE  | no cycle in progress, ready for a request
// T1    | address latched and driven; write data enabled
// T2    | strobes active; nWAIT sampled here for mem/fetch (and IO when IO_WAITS=0)
// TWA   | automatic IO wait states, IO_WAITS of them; nWAIT sampled in the last one
// TW    | external wait state, repeated while nWAIT is low
// T3    | final state of mem/IO cycles; refresh phase 1 of a fetch
// T4    | final state of a fetch (refresh phase 2)
module bus_cycle_control #(
  parameter int IO_WAITS = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req,
  input  logic [2:0] cyc_type,
  input  logic       nWAIT,
  output logic       ready,
  output logic       done,
  output logic       bus_ab_pin_we,
  output logic       bus_ab_pin_oe,
  output logic       rfsh_sel,
  output logic       bus_db_pin_re,
  output logic       ctl_bus_db_we,
  output logic       bus_db_pin_oe,
  output logic       nM1,
  output logic       nMREQ,
  output logic       nIORQ,
  output logic       nRD,
  output logic       nWR,
  output logic       nRFSH
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TWA, S_TW, S_T3, S_T4} state_t;

  localparam logic [2:0] CT_FETCH = 3'd0;
  localparam logic [2:0] CT_MRD   = 3'd1;
  localparam logic [2:0] CT_MWR   = 3'd2;
  localparam logic [2:0] CT_IORD  = 3'd3;
  localparam logic [2:0] CT_IOWR  = 3'd4;
  localparam logic [1:0] TWA_LOAD = 2'(IO_WAITS - 1);

  state_t     state, state_nxt;
  logic [2:0] cyc_q, cyc_nxt;
  logic [1:0] twa_cnt, twa_cnt_nxt;
  logic       accept, wait_req;

`ifdef BUS_CYCLE_WAIT_EN
  assign wait_req = ~nWAIT;
`else
  logic nwait_unused;
  assign nwait_unused = nWAIT;
  assign wait_req     = 1'b0;
`endif

  assign accept = req && ready && (cyc_type <= CT_IOWR);

  // Address is latched on the accept cycle and again for the refresh address in fetch T3.
  assign bus_ab_pin_we = accept || ((state == S_T3) && (cyc_q == CT_FETCH));
  assign ctl_bus_db_we = (state == S_T1) && ((cyc_q == CT_MWR) || (cyc_q == CT_IOWR));

  // Next-state logic: the IO wait counter loads on leaving T2 and counts down in TWA.
  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc_q;
    twa_cnt_nxt = twa_cnt;
    case (state)
      S_IDLE: state_nxt = S_IDLE;
      S_T1:   state_nxt = S_T2;
      S_T2: begin
        if (((cyc_q == CT_IORD) || (cyc_q == CT_IOWR)) && (IO_WAITS != 0)) begin
          state_nxt   = S_TWA;
          twa_cnt_nxt = TWA_LOAD;
        end else begin
          state_nxt = wait_req ? S_TW : S_T3;
        end
      end
      S_TWA: begin
        if (twa_cnt != 2'd0) twa_cnt_nxt = twa_cnt - 2'd1;
        else                 state_nxt   = wait_req ? S_TW : S_T3;
      end
      S_TW:    state_nxt = wait_req ? S_TW : S_T3;
      S_T3:    state_nxt = (cyc_q == CT_FETCH) ? S_T4 : S_IDLE;
      S_T4:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Acceptance is only possible in IDLE or in a final state, so it overrides the case above.
    if (accept) begin
      state_nxt = S_T1;
      cyc_nxt   = cyc_type;
    end
  end

  // State register plus Moore outputs decoded from the next state, so they are registered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state         <= S_IDLE;
      cyc_q         <= CT_FETCH;
      twa_cnt       <= 2'd0;
      ready         <= 1'b1;
      done          <= 1'b0;
      bus_ab_pin_oe <= 1'b0;
      rfsh_sel      <= 1'b0;
      bus_db_pin_re <= 1'b0;
      bus_db_pin_oe <= 1'b0;
      nM1           <= 1'b1;
      nMREQ         <= 1'b1;
      nIORQ         <= 1'b1;
      nRD           <= 1'b1;
      nWR           <= 1'b1;
      nRFSH         <= 1'b1;
    end else begin
      state         <= state_nxt;
      cyc_q         <= cyc_nxt;
      twa_cnt       <= twa_cnt_nxt;
      ready         <= (state_nxt == S_IDLE) || (state_nxt == S_T4) ||
                       ((state_nxt == S_T3) && (cyc_nxt != CT_FETCH));
      done          <= (state_nxt == S_T4) || ((state_nxt == S_T3) && (cyc_nxt != CT_FETCH));
      bus_ab_pin_oe <= bus_ab_pin_oe || (state_nxt == S_T1);
      rfsh_sel      <= (state_nxt == S_T3) && (cyc_nxt == CT_FETCH);
      bus_db_pin_re <= ((cyc_nxt == CT_FETCH) || (cyc_nxt == CT_MRD) || (cyc_nxt == CT_IORD)) &&
                       ((state_nxt == S_T2) || (state_nxt == S_TWA) || (state_nxt == S_TW));
      bus_db_pin_oe <= ((cyc_nxt == CT_MWR) || (cyc_nxt == CT_IOWR)) &&
                       (state_nxt != S_IDLE) && (state_nxt != S_T4);
      nM1           <= !((cyc_nxt == CT_FETCH) &&
                         ((state_nxt == S_T1) || (state_nxt == S_T2) || (state_nxt == S_TW)));
      nMREQ         <= !(((cyc_nxt == CT_FETCH) &&
                          ((state_nxt == S_T1) || (state_nxt == S_T2) ||
                           (state_nxt == S_TW) || (state_nxt == S_T3))) ||
                         (((cyc_nxt == CT_MRD) || (cyc_nxt == CT_MWR)) &&
                          ((state_nxt == S_T1) || (state_nxt == S_T2) || (state_nxt == S_TW))));
      nIORQ         <= !(((cyc_nxt == CT_IORD) || (cyc_nxt == CT_IOWR)) &&
                         ((state_nxt == S_T2) || (state_nxt == S_TWA) || (state_nxt == S_TW)));
      nRD           <= !((((cyc_nxt == CT_FETCH) || (cyc_nxt == CT_MRD)) &&
                          ((state_nxt == S_T1) || (state_nxt == S_T2) || (state_nxt == S_TW))) ||
                         ((cyc_nxt == CT_IORD) &&
                          ((state_nxt == S_T2) || (state_nxt == S_TWA) || (state_nxt == S_TW))));
      nWR           <= !(((cyc_nxt == CT_MWR) || (cyc_nxt == CT_IOWR)) &&
                         ((state_nxt == S_T2) || (state_nxt == S_TWA) || (state_nxt == S_TW)));
      nRFSH         <= !((cyc_nxt == CT_FETCH) && ((state_nxt == S_T3) || (state_nxt == S_T4)));
    end
  end

endmodule

// File: tb/tb_bus_cycle_control.sv
// Testbench for bus_cycle_control.
// The reference model describes each bus cycle by its clock index k = 1..L.
// Strobes and enables follow from k and L with simple arithmetic.
// A small data latch driven by bus_db_pin_re stands in for the data pin block.
module tb_bus_cycle_control;

  localparam int IOW = 1;
`ifdef BUS_CYCLE_WAIT_EN
  localparam int WE = 1;
`else
  localparam int WE = 0;
`endif

  logic       clk = 1'b0;
  logic       nreset;
  logic       req;
  logic [2:0] cyc_type;
  logic       nWAIT;
  logic       ready, done, bus_ab_pin_we, bus_ab_pin_oe, rfsh_sel, bus_db_pin_re;
  logic       ctl_bus_db_we, bus_db_pin_oe, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [7:0] db_pins, db_latch;

  bus_cycle_control #(.IO_WAITS(IOW)) dut (
    .clk(clk), .nreset(nreset), .req(req), .cyc_type(cyc_type), .nWAIT(nWAIT),
    .ready(ready), .done(done), .bus_ab_pin_we(bus_ab_pin_we), .bus_ab_pin_oe(bus_ab_pin_oe),
    .rfsh_sel(rfsh_sel), .bus_db_pin_re(bus_db_pin_re), .ctl_bus_db_we(ctl_bus_db_we),
    .bus_db_pin_oe(bus_db_pin_oe), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nRFSH(nRFSH)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_db_pin_re) db_latch <= db_pins;

  // Output vector bit order:
  // ready, done, ab_we, ab_oe, rfsh_sel, db_re, db_we, db_oe, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH
  localparam logic [13:0] RST_VEC = 14'b1000_0000_111111;

  typedef struct {
    logic        req;
    logic [2:0]  typ;
    logic        nwait;
    logic [7:0]  db;
    logic [13:0] exp;
    logic        chk_latch;
    logic [7:0]  exp_latch;
  } rec_t;

  typedef struct {
    int t;
    int nw;
    int gap;
    int len;
  } row_t;

  rec_t tq[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic oe_b = 1'b0;

  function automatic logic [13:0] act_vec();
    return {ready, done, bus_ab_pin_we, bus_ab_pin_oe, rfsh_sel, bus_db_pin_re, ctl_bus_db_we,
            bus_db_pin_oe, nM1, nMREQ, nIORQ, nRD, nWR, nRFSH};
  endfunction

  function automatic logic [13:0] idle_vec(logic oe);
    return {1'b1, 1'b0, 1'b0, oe, 4'b0000, 6'h3f};
  endfunction

  // Expected outputs in clock k (1..len) of a cycle of type t.
  function automatic logic [13:0] cyc_vec(int t, int k, int len);
    logic rdy, dn, abwe, rf, re, dbwe, dboe, m1, mreq, iorq, rd, wr, rfn;
    rdy = (k == len); dn = (k == len);
    abwe = 0; rf = 0; re = 0; dbwe = 0; dboe = 0;
    m1 = 1; mreq = 1; iorq = 1; rd = 1; wr = 1; rfn = 1;
    case (t)
      0: begin
        m1 = !(k <= len - 2); rd = m1; mreq = !(k <= len - 1);
        rfn = !(k >= len - 1); rf = (k == len - 1); abwe = (k == len - 1);
        re = (k >= 2) && (k <= len - 2);
      end
      1: begin mreq = !(k < len); rd = mreq; re = (k >= 2) && (k < len); end
      2: begin mreq = !(k < len); wr = !((k >= 2) && (k < len)); dboe = 1; dbwe = (k == 1); end
      3: begin iorq = !((k >= 2) && (k < len)); rd = iorq; re = !iorq; end
      default: begin iorq = !((k >= 2) && (k < len)); wr = iorq; dboe = 1; dbwe = (k == 1); end
    endcase
    return {rdy, dn, abwe, 1'b1, rf, re, dbwe, dboe, m1, mreq, iorq, rd, wr, rfn};
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic push(logic rq, logic [2:0] ty, logic w, logic [7:0] d, logic [13:0] e);
    rec_t r;
    r.req = rq; r.typ = ty; r.nwait = w; r.db = d; r.exp = e;
    r.chk_latch = 1'b0; r.exp_latch = 8'h00;
    tq.push_back(r);
  endtask

  // Append one request (plus its cycle, if legal) to the period trace.
  task automatic add_row(input int t, input int nw, input int gap, output int acc, output int len);
    rec_t r;
    int   ks;
    if (gap > 0 || tq.size() == 0) begin
      for (int g = 0; g < gap; g++)
        push(1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), idle_vec(oe_b));
      push(1'b0, 3'd0, 1'b1, 8'($urandom), idle_vec(oe_b));
    end
    acc = tq.size() - 1;
    r = tq[acc];
    r.req = 1'b1;
    r.typ = 3'(t);
    len = 0;
    if (t > 4) begin
      tq[acc] = r;
      push(1'b0, 3'd0, 1'b1, 8'($urandom), idle_vec(oe_b));
      return;
    end
    r.exp[11] = 1'b1;
    tq[acc] = r;
    oe_b = 1'b1;
    len = ((t == 0) ? 4 : (t >= 3) ? 3 + IOW : 3) + ((WE != 0) ? nw : 0);
    ks  = (t >= 3) ? 2 + IOW : 2;
    for (int k = 1; k <= len; k++) begin
      logic w;
      w = (k >= ks && k < ks + nw) ? 1'b0 : (k == ks + nw) ? 1'b1 : 1'($urandom);
      push((k < len) ? 1'($urandom) : 1'b0, 3'($urandom_range(0, 7)), w, 8'($urandom),
           cyc_vec(t, k, len));
    end
    if (t == 0 || t == 1 || t == 3) begin
      r = tq[acc + len];
      r.chk_latch = 1'b1;
      r.exp_latch = tq[acc + len - ((t == 0) ? 2 : 1)].db;
      tq[acc + len] = r;
    end
  endtask

  // Apply the trace one clock at a time; entered and left just after a rising edge.
  task automatic play();
    done_q.delete();
    for (int i = 0; i < tq.size(); i++) begin
      req = tq[i].req; cyc_type = tq[i].typ; nWAIT = tq[i].nwait; db_pins = tq[i].db;
      @(negedge clk);
      chk("vec", i, 32'(act_vec()), 32'(tq[i].exp));
      if (tq[i].chk_latch) chk("latch", i, 32'(db_latch), 32'(tq[i].exp_latch));
      if (done) done_q.push_back(i);
      @(posedge clk); #1;
    end
    req = 1'b0;
    tq.delete();
  endtask

  row_t tbl[11];
  int   acc_l[$];
  int   len_l[$];

  initial begin
    int a, l;
    //         type nw gap expected length
    tbl[0]  = '{0, 0, 2, 4};
    tbl[1]  = '{2, 2, 1, 3 + 2 * WE};
    tbl[2]  = '{3, 0, 1, 4};
    tbl[3]  = '{1, 0, 1, 3};
    tbl[4]  = '{2, 0, 0, 3};
    tbl[5]  = '{6, 0, 1, 0};
    tbl[6]  = '{1, 2, 0, 3 + 2 * WE};
    tbl[7]  = '{4, 1, 0, 4 + WE};
    tbl[8]  = '{0, 1, 0, 4 + WE};
    tbl[9]  = '{7, 0, 0, 0};
    tbl[10] = '{3, 3, 2, 4 + 3 * WE};

    nreset = 1'b0; req = 1'b0; cyc_type = 3'd0; nWAIT = 1'b1; db_pins = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 0, 32'(act_vec()), 32'(RST_VEC));
    nreset = 1'b1;

    // Reset asserted in the middle of a fetch.
    req = 1'b1; cyc_type = 3'd0;
    @(negedge clk);
    chk("rst_accept_we", 0, 32'(bus_ab_pin_we), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_t2_nm1", 0, 32'(nM1), 32'd0);
    #2 nreset = 1'b0;
    #1 chk("rst_async", 0, 32'(act_vec()), 32'(RST_VEC));
    @(posedge clk); #1;
    chk("rst_hold", 0, 32'(act_vec()), 32'(RST_VEC));
    nreset = 1'b1;
    @(negedge clk);
    chk("rst_idle", 0, 32'(act_vec()), 32'(idle_vec(1'b0)));
    @(posedge clk); #1;
    oe_b = 1'b0;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      add_row(tbl[i].t, tbl[i].nw, tbl[i].gap, a, l);
      if (tbl[i].t <= 4) begin acc_l.push_back(a); len_l.push_back(tbl[i].len); end
    end
    push(1'b0, 3'd0, 1'b1, 8'h00, idle_vec(oe_b));
    play();
    chk("tbl_done_count", 0, 32'(done_q.size()), 32'(acc_l.size()));
    for (int j = 0; j < acc_l.size() && j < done_q.size(); j++)
      chk("tbl_cycle_len", j, 32'(done_q[j] - acc_l[j]), 32'(len_l[j]));
    acc_l.delete(); len_l.delete();

    // Data latch captures 8'hA5 through an IO read.
    add_row(3, 0, 1, a, l);
    for (int k = 1; k <= l; k++) begin
      rec_t r;
      r = tq[a + k];
      r.db = (k == l - 1) ? 8'hA5 : 8'h5A;
      if (k == l) r.exp_latch = 8'hA5;
      tq[a + k] = r;
    end
    play();

    // Randomized requests against the model.
    for (int i = 0; i < 40; i++) begin
      int t;
      t = $urandom_range(0, 7);
      add_row(t, $urandom_range(0, 3), $urandom_range(0, 2), a, l);
      if (t <= 4) begin acc_l.push_back(a); len_l.push_back(l); end
    end
    push(1'b0, 3'd0, 1'b1, 8'h00, idle_vec(oe_b));
    play();
    chk("rnd_done_count", 0, 32'(done_q.size()), 32'(acc_l.size()));
    for (int j = 0; j < acc_l.size() && j < done_q.size(); j++)
      chk("rnd_cycle_len", j, 32'(done_q[j] - acc_l[j]), 32'(len_l[j]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
